// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/ram_arb_sel.sv
// Combinational grant selection: burst-limited round-robin between m0 and m1.
module ram_arb_sel
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  arb_state_t       st,
  input  logic             last,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       req,
  output logic             gnt,
  output logic             owner
);

  logic cur;
  logic cur_req;
  logic oth_req;

  always_comb begin
    gnt     = 1'b0;
    owner   = REQ_M0;
    cur     = (st == ARB_OWN1) ? REQ_M1 : REQ_M0;
    cur_req = (cur == REQ_M1) ? req[1] : req[0];
    oth_req = (cur == REQ_M1) ? req[0] : req[1];
    case (st)
      ARB_IDLE: begin
        // On a tie the master that did not go last wins.
        if (req[0] && req[1]) begin
          gnt   = 1'b1;
          owner = ~last;
        end else if (req[0]) begin
          gnt   = 1'b1;
          owner = REQ_M0;
        end else if (req[1]) begin
          gnt   = 1'b1;
          owner = REQ_M1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (cur_req && (!oth_req || (cnt < CNT_W'(MAX_BURST)))) begin
          gnt   = 1'b1;
          owner = cur;
        end else if (oth_req) begin
          gnt   = 1'b1;
          owner = ~cur;
        end
      end
      default: begin
        gnt   = 1'b0;
        owner = REQ_M0;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between m0 (core) and m1 (loader DMA); grants are
// combinational, read data returns to the issuing master one cycle later.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_re,
  input  logic [3:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic              m1_req,
  input  logic              m1_re,
  input  logic [3:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [31:0]       m0_rdata,
  output logic [31:0]       m1_rdata,
  output logic              ram_r,
  output logic [3:0]        ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_in,
  input  logic [31:0]       ram_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       st, st_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rd_pend;
  logic             rd_tag;

  logic             sel_gnt;
  logic             gnt;
  logic             owner;
  logic             g_re;
  logic [3:0]       g_we;

  ram_arb_sel #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_sel (
    .st    (st),
    .last  (last),
    .cnt   (cnt),
    .req   ({m1_req, m0_req}),
    .gnt   (sel_gnt),
    .owner (owner)
  );

  // Grants are combinational from req, so they are held off while in reset.
  assign gnt    = sel_gnt && !rst;
  assign m0_gnt = gnt && (owner == REQ_M0);
  assign m1_gnt = gnt && (owner == REQ_M1);

  always_comb begin
    st_nxt   = st;
    last_nxt = last;
    cnt_nxt  = cnt;
    if (!gnt) begin
      st_nxt  = ARB_IDLE;
      cnt_nxt = '0;
    end else if ((st != ARB_IDLE) && (owner == ((st == ARB_OWN1) ? REQ_M1 : REQ_M0))) begin
      if (cnt != CNT_W'(MAX_BURST)) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      st_nxt   = (owner == REQ_M1) ? ARB_OWN1 : ARB_OWN0;
      cnt_nxt  = CNT_W'(1);
      last_nxt = owner;
    end
  end

  always_comb begin
    g_re     = (owner == REQ_M1) ? m1_re : m0_re;
    g_we     = (owner == REQ_M1) ? m1_we : m0_we;
    ram_r    = 1'b0;
    ram_w    = 4'h0;
    ram_addr = '0;
    ram_in   = '0;
    if (gnt) begin
      // A write wins over a simultaneous read; no read data is returned.
      ram_r    = g_re && (g_we == 4'h0);
      ram_w    = g_we;
      ram_addr = (owner == REQ_M1) ? m1_addr : m0_addr;
      ram_in   = (owner == REQ_M1) ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ARB_IDLE;
      last    <= REQ_M1;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= REQ_M0;
    end else begin
      st      <= st_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= ram_r;
      if (ram_r) begin
        rd_tag <= owner;
      end
    end
  end

  assign m0_rvalid = rd_pend && (rd_tag == REQ_M0);
  assign m1_rvalid = rd_pend && (rd_tag == REQ_M1);
  assign m0_rdata  = m0_rvalid ? ram_out : 32'h0;
  assign m1_rdata  = m1_rvalid ? ram_out : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a RAM model and a read-return scoreboard.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  typedef struct {
    logic        req;
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        tag;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_re, m1_re;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_r;
  logic [3:0]  ram_w;
  logic [31:0] ram_addr, ram_in;
  logic [31:0] ram_out = 32'h0;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  sb_t         sb[$];

  always #5 clk = ~clk;

  ram_arbiter #(.MAX_BURST(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_in(ram_in),
    .ram_out(ram_out)
  );

  // RAM model: one-cycle read latency; junk on ram_out when not reading.
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_r) ram_out <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
    else       ram_out <= 32'h5A5A_5A5A;
    if (|ram_w) begin
      w = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (ram_w[b]) w[b*8 +: 8] = ram_in[b*8 +: 8];
      mem[ram_addr] = w;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t acc(input logic req, input logic re, input logic [3:0] we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    acc_t a;
    a.req = req; a.re = re; a.we = we; a.addr = addr; a.wdata = wdata;
    return a;
  endfunction

  function automatic acc_t none();
    return acc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endfunction

  task automatic drive(input acc_t a0, input acc_t a1);
    m0_req = a0.req; m0_re = a0.re; m0_we = a0.we; m0_addr = a0.addr; m0_wdata = a0.wdata;
    m1_req = a1.req; m1_re = a1.re; m1_we = a1.we; m1_addr = a1.addr; m1_wdata = a1.wdata;
  endtask

  task automatic check_rv();
    sb_t         e;
    logic [1:0]  ev = 2'b00;
    logic [31:0] d0 = 32'h0;
    logic [31:0] d1 = 32'h0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.tag) begin ev = 2'b10; d1 = e.data; end
      else       begin ev = 2'b01; d0 = e.data; end
    end
    chk("rvalid", {62'h0, m1_rvalid, m0_rvalid}, {62'h0, ev});
    chk("m0_rdata", {32'h0, m0_rdata}, {32'h0, d0});
    chk("m1_rdata", {32'h0, m1_rdata}, {32'h0, d1});
  endtask

  // One clock cycle: drive, check grant and RAM strobes, then check read return.
  task automatic cyc(input acc_t a0, input acc_t a1, input logic [1:0] eg);
    acc_t        g;
    sb_t         e;
    logic        er = 1'b0;
    logic [3:0]  ew = 4'h0;
    logic [31:0] ea = 32'h0;
    logic [31:0] ed = 32'h0;
    logic [31:0] w;
    drive(a0, a1);
    #2;
    chk("gnt", {62'h0, m1_gnt, m0_gnt}, {62'h0, eg});
    g = eg[1] ? a1 : a0;
    if (eg != 2'b00) begin
      er = g.re && (g.we == 4'h0);
      ew = g.we; ea = g.addr; ed = g.wdata;
    end
    chk("ram_r", {63'h0, ram_r}, {63'h0, er});
    chk("ram_w", {60'h0, ram_w}, {60'h0, ew});
    chk("ram_addr", {32'h0, ram_addr}, {32'h0, ea});
    chk("ram_in", {32'h0, ram_in}, {32'h0, ed});
    if (er) begin
      e.tag  = eg[1];
      e.data = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
      sb.push_back(e);
    end
    if (|ew) begin
      w = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (ew[b]) w[b*8 +: 8] = ed[b*8 +: 8];
      ref_mem[ea] = w;
    end
    @(posedge clk);
    #1;
    check_rv();
  endtask

  task automatic do_reset();
    drive(none(), none());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Reset: requests are present but nothing may be granted or strobed.
    rst = 1'b1;
    drive(acc(1'b1, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF), acc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0));
    @(posedge clk);
    #3;
    chk("rst_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h0);
    chk("rst_ram_w", {60'h0, ram_w}, 64'h0);
    chk("rst_ram_r", {63'h0, ram_r}, 64'h0);
    chk("rst_ram_addr", {32'h0, ram_addr}, 64'h0);
    chk("rst_rvalid", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // m0 write, idle, then m1 reads it back.
    cyc(acc(1'b1, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF), none(), 2'b01);
    cyc(none(), none(), 2'b00);
    cyc(none(), acc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0), 2'b10);
    cyc(none(), none(), 2'b00);

    // Both requesting from reset: 4 m0 reads (back-to-back), 4 m1 writes, 4 m0 reads.
    do_reset();
    for (int i = 0; i < 12; i++)
      cyc(acc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0),
          acc(1'b1, 1'b0, 4'h3, 32'h20, 32'h1000 + i),
          (i >= 4 && i < 8) ? 2'b10 : 2'b01);
    cyc(none(), none(), 2'b00);
    cyc(none(), acc(1'b1, 1'b1, 4'h0, 32'h20, 32'h0), 2'b10);

    // Tie after idle with last=m0 goes to m1; m0 follows once m1 drops.
    do_reset();
    cyc(acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), none(), 2'b01);
    cyc(none(), none(), 2'b00);
    cyc(acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), 2'b10);
    cyc(acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), none(), 2'b01);

    // Lone owner past the burst limit keeps the grant; a waiter then takes over.
    for (int i = 0; i < 6; i++)
      cyc(acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), none(), 2'b01);
    cyc(acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), 2'b10);
    cyc(none(), none(), 2'b00);

    // m0 read returns while m1 holds the grant.
    cyc(acc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0), none(), 2'b01);
    cyc(none(), acc(1'b1, 1'b0, 4'hF, 32'h40, 32'hCAFE_F00D), 2'b10);

    // re+we is a write without read return; partial byte write then read back.
    cyc(acc(1'b1, 1'b1, 4'h1, 32'h10, 32'h0000_0011), none(), 2'b01);
    cyc(acc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0), none(), 2'b01);
    cyc(none(), acc(1'b1, 1'b1, 4'h0, 32'h40, 32'h0), 2'b10);
    cyc(none(), none(), 2'b00);

    // Reset in the cycle after a granted m0 read drops the return.
    drive(acc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0), none());
    #2;
    chk("mid_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rvalid", {63'h0, m0_rvalid}, 64'h0);
    chk("mid_rdata", {32'h0, m0_rdata}, 64'h0);
    chk("mid_gnt_rst", {62'h0, m1_gnt, m0_gnt}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    cyc(none(), none(), 2'b00);
    cyc(acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0), 2'b01);
    cyc(none(), none(), 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between two requesters: m0 (core data port) and m1 (debug/loader DMA port).
- Grants one requester per cycle with burst-limited round-robin.
- Drives the RAM strobes and routes registered read data back to the issuer.
- Sits in the SoC between the core/loader and the RAM instance; the RAM read has 1-cycle latency.

Parameters:
- MAX_BURST, 4: maximum consecutive grants to one owner while the other requester waits (≥1).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req, m1_req  in  1  access request.
- m0_re, m1_re  in  1  read access.
- m0_we, m1_we  in  4  byte write enables.
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_gnt, m1_gnt  out  1  grant; combinational, same cycle as req.
- m0_rvalid, m1_rvalid  out  1  read data valid, one cycle after the granted read.
- m0_rdata, m1_rdata  out  32  read data; 0 when rvalid=0.
- ram_r  out  1  RAM read strobe.
- ram_w  out  4  RAM byte write strobes.
- ram_addr  out  ADDR_W  RAM address.
- ram_in  out  32  write data to RAM.
- ram_out  in  32  RAM read data, valid the cycle after ram_r.

Behaviour:
- Transfer rule: an access completes on the rising edge where mX_req && mX_gnt. At most one gnt is high per cycle; gnt is never high without req.
- Registered state: st ∈ {IDLE, OWN0, OWN1}, last (most recent owner), cnt (consecutive grants to the current owner, width clog2(MAX_BURST+1)), rd_pend, rd_tag.
- Reset (async): st=IDLE, last=1 (so m0 wins the first tie), cnt=0, rd_pend=0. All outputs 0 during and immediately after reset.
- Grant selection (combinational from state and reqs):
  - IDLE: single req → grant it. Both → grant the one ≠ last.
  - OWNx: mx_req && (!other_req || cnt < MAX_BURST) → keep x. Else other_req → grant other. Else no grant.
- Next state:
  - Grant to the same owner → cnt+1, saturating at MAX_BURST.
  - Grant to a new owner → cnt=1, last=new owner, st=OWNnew.
  - No grant → st=IDLE, cnt=0; last is unchanged.
- RAM drive when a grant is given: ram_addr/ram_in from the granted master; ram_w = we.
  - ram_r = re && (we==0). Write takes precedence; a simultaneous re+we is treated as a write with no rvalid.
  - A grant with re=0 and we=0 is a null access: it consumes the slot but strobes stay 0.
- RAM drive with no grant: ram_r=0, ram_w=0, ram_addr=0, ram_in=0.
- Read return: on a granted read, rd_pend←1 and rd_tag←owner. Next cycle, m[rd_tag]_rvalid=1 and m[rd_tag]_rdata=ram_out. rd_pend clears unless another read is granted (back-to-back reads give rvalid every cycle).
- Read return is independent of the current grant: a read by m0 followed by a grant to m1 still returns to m0.
- Fairness: with MAX_BURST=N and both requesting continuously, the pattern is N grants to one master, then N to the other. A waiting master is granted within N cycles.
- Reset mid-read: the pending rvalid is dropped and is not re-issued after reset.
- A requester may drop req without being granted; no state changes for it.

Decomposition:
- Shared package ram_arb_pkg:
  - enum arb_state_t {ARB_IDLE, ARB_OWN0, ARB_OWN1}.
  - Constants REQ_M0=0, REQ_M1=1.
- Sub-module ram_arb_sel: purely combinational next-owner/grant selection taking (st, last, cnt, reqs). The parent holds the state registers, RAM muxing and read-return tracking.

Test Plan (MAX_BURST=4):
- Reset then m0 write: m0_req=1, we=4'hF, addr=0x10, wdata=0xDEADBEEF → m0_gnt=1 same cycle; ram_w=4'hF, ram_addr=0x10, ram_in=0xDEADBEEF; next cycle m0_req=0 → all ram strobes 0.
- m1 read addr 0x10 after the above write → m1_gnt=1, ram_r=1; next cycle m1_rvalid=1, m1_rdata=0xDEADBEEF; m0_rvalid stays 0.
- Both req continuously for 12 cycles from reset → grant sequence m0×4, m1×4, m0×4; never both gnt.
- Simultaneous first request after idle with last=0 → m1 granted; m0 granted the following cycle if m1 drops req.
- m0 read granted, m1 granted the next cycle → m0_rvalid=1 with ram_out while m1_gnt=1; m1_rvalid=0.
- rst asserted in the cycle after a granted read → m0_rvalid=0 immediately (async); after release st=IDLE and no spurious rvalid.
